// File: rtl/riscv_lsu.sv
`default_nettype none
// ============================================================================
// Module      : riscv_lsu
// Description : Load/store unit. Takes a decoded memory request from the
//               core, drives a word-wide data memory using byte enables and a
//               ready handshake, and stalls the core until the access
//               completes. Returns sign- or zero-extended load data.
//               Optional macro LSU_MISALIGN_EXC_EN: misaligned half/word
//               accesses are trapped (no memory access, lsu_misalign_o pulse)
//               instead of being truncated to the aligned lane.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_lsu #(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [2:0]        core_size_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [31:0]       core_wd_i,
  output logic [31:0]       core_rd_o,
  output logic              core_stall_o,
  output logic              lsu_misalign_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wd_o,
  input  logic [31:0]       mem_rd_i,
  input  logic              mem_ready_i
);

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                we_q;
  logic [2:0]          size_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wd_q;
  logic [31:0]         core_rd_q, core_rd_d;

  logic                req_valid;
  logic                req_trap;
  logic [1:0]          a_q;
  logic [3:0]          be_w;
  logic [31:0]         wd_fmt;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;
  logic [31:0]         ld_fmt;

  // Only the five decoder encodings start a real access.
  assign req_valid = (core_size_i == LDST_B)  || (core_size_i == LDST_H) ||
                     (core_size_i == LDST_W)  || (core_size_i == LDST_BU) ||
                     (core_size_i == LDST_HU);

`ifdef LSU_MISALIGN_EXC_EN
  logic req_misalign;
  logic exc_q;

  // Half with odd address, or word not on a 4-byte boundary.
  assign req_misalign = ((core_size_i[1:0] == 2'b01) && core_addr_i[0]) ||
                        ((core_size_i == LDST_W) && (core_addr_i[1:0] != 2'b00));
  assign req_trap       = req_valid && req_misalign;
  assign lsu_misalign_o = (state_q == DONE) && exc_q;

  // Remember whether the captured request was trapped, for the DONE pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exc_q <= 1'b0;
    end else if (state_q == IDLE && core_req_i) begin
      exc_q <= req_trap;
    end
  end
`else
  assign req_trap       = 1'b0;
  assign lsu_misalign_o = 1'b0;
`endif

  // State register and captured request; the request is only sampled in IDLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      size_q    <= 3'd0;
      addr_q    <= '0;
      wd_q      <= 32'd0;
      core_rd_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      core_rd_q <= core_rd_d;
      if (state_q == IDLE && core_req_i) begin
        we_q   <= core_we_i;
        size_q <= core_size_i;
        addr_q <= core_addr_i;
        wd_q   <= core_wd_i;
      end
    end
  end

  assign a_q = addr_q[1:0];

  // Byte enables from captured size and low address bits.
  always_comb begin
    be_w = 4'b0000;
    case (size_q[1:0])
      2'b00:   be_w = 4'b0001 << a_q;
      2'b01:   be_w = 4'b0011 << {a_q[1], 1'b0};
      2'b10:   be_w = 4'b1111;
      default: be_w = 4'b0000;
    endcase
  end

  // Store data replicated across lanes so the byte enables select it.
  always_comb begin
    wd_fmt = wd_q;
    case (size_q[1:0])
      2'b00:   wd_fmt = {4{wd_q[7:0]}};
      2'b01:   wd_fmt = {2{wd_q[15:0]}};
      default: wd_fmt = wd_q;
    endcase
  end

  // Load lane extraction and extension; size bit 2 marks unsigned loads.
  always_comb begin
    ld_byte = 8'd0;
    case (a_q)
      2'd0: ld_byte = mem_rd_i[7:0];
      2'd1: ld_byte = mem_rd_i[15:8];
      2'd2: ld_byte = mem_rd_i[23:16];
      2'd3: ld_byte = mem_rd_i[31:24];
      default: ld_byte = 8'd0;
    endcase
    ld_half = a_q[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
    case (size_q[1:0])
      2'b00:   ld_fmt = {{24{ld_byte[7] & ~size_q[2]}}, ld_byte};
      2'b01:   ld_fmt = {{16{ld_half[15] & ~size_q[2]}}, ld_half};
      default: ld_fmt = mem_rd_i;
    endcase
  end

  // Next-state and load-result update.
  always_comb begin
    state_d   = state_q;
    core_rd_d = core_rd_q;
    case (state_q)
      IDLE: begin
        if (core_req_i) begin
          if (!req_valid || req_trap) begin
            state_d   = DONE;
            core_rd_d = 32'd0;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (mem_ready_i) begin
          state_d = DONE;
          if (!we_q) begin
            core_rd_d = ld_fmt;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory port is driven only while BUSY; zero otherwise.
  assign mem_req_o  = (state_q == BUSY);
  assign mem_we_o   = (state_q == BUSY) && we_q;
  assign mem_be_o   = (state_q == BUSY) ? be_w : 4'b0000;
  assign mem_addr_o = (state_q == BUSY) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_wd_o   = (state_q == BUSY) ? wd_fmt : 32'd0;

  // Stall in IDLE follows the request combinationally; rst_ni gates it so a
  // request presented during reset does not stall the core.
  assign core_stall_o = (state_q == BUSY) ||
                        ((state_q == IDLE) && core_req_i && rst_ni);
  assign core_rd_o    = core_rd_q;

endmodule
`default_nettype wire
